// File: rtl/layer_collect_block.sv
// Serial-to-parallel collector: packs elem_n serial words into a shadow
// register and publishes the full vector atomically with a one-cycle done pulse.
module layer_collect_block #(
  parameter int unsigned elem_n     = 5,
  parameter int unsigned data_width = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_in,
  input  logic                         valid_in,
  input  logic [data_width-1:0]        data_in,
  output logic [data_width*elem_n-1:0] data_out,
  output logic                         done_out,
  output logic                         busy,
  output logic                         drop_out
);

  localparam int unsigned IDX_W = (elem_n > 1) ? $clog2(elem_n) : 1;
  localparam int unsigned VEC_W = data_width * elem_n;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(elem_n - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [VEC_W-1:0] shadow_q, shadow_d;
  logic [VEC_W-1:0] data_out_d;
  logic             done_d, drop_d;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  // Next-state, slot write and publish decisions
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    data_out_d = data_out;
    done_d     = 1'b0;
    drop_d     = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = '0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = COLLECT;
          idx_d   = '0;
          wr_en   = valid_in;
        end else if (valid_in) begin
          drop_d = 1'b1;
        end
      end
      COLLECT: begin
        if (start_in) begin
          // Restart discards the partial vector; a coincident word becomes word 0
          drop_d = 1'b1;
          idx_d  = '0;
          wr_en  = valid_in;
        end else if (valid_in) begin
          wr_en  = 1'b1;
          wr_idx = idx_q;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned k = 0; k < elem_n; k++) begin
      if (wr_en && (wr_idx == IDX_W'(k))) begin
        shadow_d[k*data_width +: data_width] = data_in;
      end
    end

    if (wr_en) begin
      if (wr_idx == LAST_IDX) begin
        data_out_d = shadow_d;
        done_d     = 1'b1;
        state_d    = IDLE;
        idx_d      = '0;
      end else begin
        idx_d = wr_idx + IDX_W'(1);
      end
    end
  end

  // State, shadow and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      data_out <= '0;
      done_out <= 1'b0;
      drop_out <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      data_out <= data_out_d;
      done_out <= done_d;
      drop_out <= drop_d;
      busy     <= (state_d == COLLECT);
    end
  end

endmodule

// File: tb/tb_layer_collect_block.sv
// Bench for layer_collect_block: directed table, hand sequences, and random
// stimulus against a queue-based reference model.
module tb_layer_collect_block;

  localparam int unsigned N  = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned VW = N * DW;

  logic          clk = 1'b0;
  logic          rst, start_in, valid_in;
  logic [DW-1:0] data_in;
  logic [VW-1:0] data_out;
  logic          done_out, busy, drop_out;

  logic          start1, valid1;
  logic [DW-1:0] data1_in;
  logic [DW-1:0] data1_out;
  logic          done1, busy1, drop1;

  layer_collect_block #(.elem_n(N), .data_width(DW)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .valid_in(valid_in),
    .data_in(data_in), .data_out(data_out), .done_out(done_out),
    .busy(busy), .drop_out(drop_out)
  );

  layer_collect_block #(.elem_n(1), .data_width(DW)) dut1 (
    .clk(clk), .rst(rst), .start_in(start1), .valid_in(valid1),
    .data_in(data1_in), .data_out(data1_out), .done_out(done1),
    .busy(busy1), .drop_out(drop1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: words collected so far, plus expected outputs
  bit            m_active;
  logic [DW-1:0] m_words[$];
  logic [VW-1:0] m_data;
  bit            m_done, m_drop;

  task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
    logic [VW-1:0] p;
    if (r) begin
      m_active = 1'b0;
      m_words.delete();
      m_data = '0;
      m_done = 1'b0;
      m_drop = 1'b0;
      return;
    end
    m_done = 1'b0;
    m_drop = 1'b0;
    if (s) begin
      if (m_active) m_drop = 1'b1;
      m_words.delete();
      m_active = 1'b1;
      if (v) m_words.push_back(d);
    end else if (v) begin
      if (m_active) m_words.push_back(d);
      else m_drop = 1'b1;
    end
    if (m_active && m_words.size() == N) begin
      p = '0;
      for (int i = 0; i < int'(N); i++) p[i*DW +: DW] = m_words[i];
      m_data = p;
      m_done = 1'b1;
      m_active = 1'b0;
      m_words.delete();
    end
  endtask

  // Apply one cycle of inputs and compare main DUT against the model
  task automatic cycle(input logic r, input logic s, input logic v, input logic [DW-1:0] d);
    rst = r; start_in = s; valid_in = v; data_in = d;
    model_step(r, s, v, d);
    @(posedge clk);
    #1;
    chk("model_data_out", data_out, m_data);
    chk("model_done", VW'(done_out), VW'(m_done));
    chk("model_drop", VW'(drop_out), VW'(m_drop));
    chk("model_busy", VW'(busy), VW'(m_active));
    start1 = 1'b0; valid1 = 1'b0;
  endtask

  typedef struct {
    logic          r, s, v;
    logic [DW-1:0] d;
    logic          done, drop, bsy;
    logic [VW-1:0] dout;
  } vec_t;

  vec_t          tbl[26];
  logic [VW-1:0] prev;
  int            dones;

  initial begin
    rst = 1'b1; start_in = 1'b0; valid_in = 1'b0; data_in = '0;
    start1 = 1'b0; valid1 = 1'b0; data1_in = '0;

    //            r  s  v  data      done drop busy data_out
    tbl[0]  = '{1, 0, 0, 16'h0000, 0, 0, 0, 80'h0};
    tbl[1]  = '{0, 1, 1, 16'h0001, 0, 0, 1, 80'h0};
    tbl[2]  = '{0, 0, 1, 16'h0002, 0, 0, 1, 80'h0};
    tbl[3]  = '{0, 0, 1, 16'h0003, 0, 0, 1, 80'h0};
    tbl[4]  = '{0, 0, 1, 16'h0004, 0, 0, 1, 80'h0};
    tbl[5]  = '{0, 0, 1, 16'h0005, 1, 0, 0, 80'h0005_0004_0003_0002_0001};
    tbl[6]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 80'h0005_0004_0003_0002_0001};
    tbl[7]  = '{0, 0, 1, 16'hDEAD, 0, 1, 0, 80'h0005_0004_0003_0002_0001};
    tbl[8]  = '{0, 0, 0, 16'h0000, 0, 0, 0, 80'h0005_0004_0003_0002_0001};
    tbl[9]  = '{0, 1, 1, 16'hAAAA, 0, 0, 1, 80'h0005_0004_0003_0002_0001};
    tbl[10] = '{0, 0, 1, 16'hBBBB, 0, 0, 1, 80'h0005_0004_0003_0002_0001};
    tbl[11] = '{0, 1, 1, 16'h1111, 0, 1, 1, 80'h0005_0004_0003_0002_0001};
    tbl[12] = '{0, 0, 1, 16'h2222, 0, 0, 1, 80'h0005_0004_0003_0002_0001};
    tbl[13] = '{0, 0, 1, 16'h3333, 0, 0, 1, 80'h0005_0004_0003_0002_0001};
    tbl[14] = '{0, 0, 1, 16'h4444, 0, 0, 1, 80'h0005_0004_0003_0002_0001};
    tbl[15] = '{0, 0, 1, 16'h5555, 1, 0, 0, 80'h5555_4444_3333_2222_1111};
    tbl[16] = '{0, 1, 1, 16'h00A0, 0, 0, 1, 80'h5555_4444_3333_2222_1111};
    tbl[17] = '{0, 0, 1, 16'h00A1, 0, 0, 1, 80'h5555_4444_3333_2222_1111};
    tbl[18] = '{0, 0, 1, 16'h00A2, 0, 0, 1, 80'h5555_4444_3333_2222_1111};
    tbl[19] = '{1, 0, 0, 16'h0000, 0, 0, 0, 80'h0};
    tbl[20] = '{0, 1, 0, 16'h0000, 0, 0, 1, 80'h0};
    tbl[21] = '{0, 0, 1, 16'h0011, 0, 0, 1, 80'h0};
    tbl[22] = '{0, 0, 1, 16'h0012, 0, 0, 1, 80'h0};
    tbl[23] = '{0, 0, 1, 16'h0013, 0, 0, 1, 80'h0};
    tbl[24] = '{0, 0, 1, 16'h0014, 0, 0, 1, 80'h0};
    tbl[25] = '{0, 0, 1, 16'h0015, 1, 0, 0, 80'h0015_0014_0013_0012_0011};

    for (int i = 0; i < 26; i++) begin
      cycle(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_data_out", i), data_out, tbl[i].dout);
      chk($sformatf("tbl%0d_done", i), VW'(done_out), VW'(tbl[i].done));
      chk($sformatf("tbl%0d_drop", i), VW'(drop_out), VW'(tbl[i].drop));
      chk($sformatf("tbl%0d_busy", i), VW'(busy), VW'(tbl[i].bsy));
    end

    // Gapped valids: data_out holds until the single completion
    prev  = 80'h0015_0014_0013_0012_0011;
    dones = 0;
    cycle(1'b0, 1'b1, 1'b1, 16'h0001);
    chk("gap_hold_first", data_out, prev);
    for (int w = 2; w <= 5; w++) begin
      for (int g = 0; g < 2; g++) begin
        cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("gap_hold_idle", data_out, prev);
        if (done_out) dones++;
      end
      cycle(1'b0, 1'b0, 1'b1, DW'(w));
      if (done_out) dones++;
      if (w < 5) chk("gap_hold_word", data_out, prev);
    end
    chk("gap_data_out", data_out, 80'h0005_0004_0003_0002_0001);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    if (done_out) dones++;
    chk("gap_done_count", VW'(dones), VW'(1));

    // elem_n == 1: same-cycle start and word completes immediately
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("n1_reset_data", VW'(data1_out), VW'(0));
    start1 = 1'b1; valid1 = 1'b1; data1_in = 16'h7E7E;
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("n1_done", VW'(done1), VW'(1));
    chk("n1_data_out", VW'(data1_out), VW'(16'h7E7E));
    chk("n1_busy", VW'(busy1), VW'(0));
    chk("n1_drop", VW'(drop1), VW'(0));
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("n1_done_low", VW'(done1), VW'(0));
    chk("n1_busy_low", VW'(busy1), VW'(0));
    chk("n1_data_hold", VW'(data1_out), VW'(16'h7E7E));

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1), DW'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_collect_block.md
Name: layer_collect_block

Overview:
- Serial-to-parallel collector. It is the write-side counterpart of the weight/address sequencer.
- It accepts one data_width-bit word per valid cycle from a neuron output stream and packs elem_n words into a shadow register.
- On completion it atomically publishes the packed vector with a one-cycle done pulse, so the next layer sees a stable parallel bus.
- It sits between a layer's serial output and the following layer's parallel data input.

Parameters:
- elem_n, 5, number of words per vector (>=1).
- data_width, 16, bits per word.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start_in  input  1  one-cycle pulse marking the start of a new vector
- valid_in  input  1  data_in carries a word this cycle
- data_in  input  data_width  serial word
- data_out  output  data_width*elem_n  published packed vector, registered
- done_out  output  1  one-cycle pulse, data_out just updated
- busy  output  1  high while in COLLECT
- drop_out  output  1  one-cycle pulse flagging a discarded word or aborted vector

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; rst has priority over all inputs.
- Reset values:
  - state IDLE, index 0
  - shadow all-zero, data_out all-zero
  - done_out 0, busy 0, drop_out 0
- Index register width is max(1,$clog2(elem_n)).
- Packing rule: word k lands at bits [data_width*k +: data_width]. Word 0 is the first accepted word, matching sequencer address order.
- States: IDLE and COLLECT.
- IDLE behaviour:
  - start_in: go to COLLECT, index 0.
  - start_in & valid_in in the same cycle: capture data_in as word 0, index 1.
  - If elem_n==1, that same-cycle capture completes the vector immediately and the block stays in IDLE.
  - valid_in without start_in: word ignored, drop_out=1 next cycle, no state change.
- COLLECT, valid_in, no start_in:
  - Write data_in into slot index, then index++.
  - If index==elem_n-1 (final word): data_out <= shadow with the final word merged; done_out=1 the next cycle; state to IDLE; index 0.
- COLLECT, start_in (abort/restart):
  - Partial vector is discarded and drop_out=1 next cycle.
  - data_out is unchanged and done_out is not pulsed.
  - Index returns to 0 and the block stays in COLLECT.
  - If valid_in is also high, data_in is captured as word 0 of the new vector, index 1.
  - start_in wins over completion: a final-word valid_in coincident with start_in becomes word 0 of the new vector.
- COLLECT, no valid_in: hold. There is no timeout.
- Latency: the final word is accepted at edge E. data_out is updated and done_out is high during the cycle following E. done_out is high for exactly one cycle.
- Back-to-back vectors: start_in may arrive on the cycle done_out is high; it is accepted normally.
- data_out changes only on completion or rst, never during collection.
- Shadow is not cleared between vectors; stale slots are always overwritten before publish.
- busy = (state==COLLECT), registered.
- rst mid-collect: partial vector lost, data_out cleared, no done_out or drop_out pulse.

Test Plan:
- Basic pack, elem_n=5, data_width=16:
  - Stimulus: start_in with valid 0x0001, then valids 0x0002..0x0005 on consecutive cycles.
  - Required: data_out = 0x0005_0004_0003_0002_0001 and done_out high for one cycle, in the cycle after the 0x0005 edge; busy falls at the same time.
- Gapped valids:
  - Stimulus: same 5 words with 2 idle cycles between each.
  - Required: identical data_out; done_out exactly once; data_out holds the previous value throughout collection.
- Abort:
  - Stimulus: start, words 0xAAAA and 0xBBBB, then start_in with valid 0x1111, then 0x2222..0x5555.
  - Required: drop_out pulses once; data_out = 0x5555_4444_3333_2222_1111; done_out exactly once.
- Stray valid:
  - Stimulus: valid_in 0xDEAD in IDLE.
  - Required: drop_out pulse; data_out, busy and done_out unchanged.
- Reset mid-operation:
  - Stimulus: rst after 3 words of a vector, with a prior published vector.
  - Required: data_out == 0, busy 0, no done_out. A following full vector publishes correctly.
- elem_n=1:
  - Stimulus: start_in & valid_in with 0x7E7E.
  - Required: done_out the next cycle; data_out=0x7E7E; busy never asserted.
